// File: rtl/pipe_mux_n.sv
// rtl/pipe_mux_n.sv - N-way select mux feeding a 2-entry elastic skid output stage
// Optional feature macro: PIPE_MUX_SELCHK_EN (sticky out-of-range select flag)
module pipe_mux_n #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    sel_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t             state;
  logic               accept;
  logic               pop;
  logic               sel_hit;
  logic [WIDTH-1:0]   match_data;
  logic [WIDTH-1:0]   word;
  logic [WIDTH-1:0]   skid_data;
  logic [SEL_W-1:0]   skid_sel;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  // Decode the select; a select with no matching input yields an all-zero word
  always_comb begin
    match_data = '0;
    sel_hit    = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        match_data = in_data[k*WIDTH +: WIDTH];
        sel_hit    = 1'b1;
      end
    end
  end

  assign word = sel_hit ? match_data : '0;

  // Skid-buffer control: main register drives the output, skid absorbs one stalled word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_data  <= '0;
      out_sel   <= '0;
      skid_data <= '0;
      skid_sel  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            out_data  <= word;
            out_sel   <= sel;
            state     <= ONE;
            out_valid <= 1'b1;
            in_ready  <= 1'b1;
          end
        end
        ONE: begin
          if (accept && !pop) begin
            skid_data <= word;
            skid_sel  <= sel;
            state     <= TWO;
            out_valid <= 1'b1;
            in_ready  <= 1'b0;
          end else if (pop && !accept) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end else if (accept && pop) begin
            out_data  <= word;
            out_sel   <= sel;
          end
        end
        TWO: begin
          if (pop) begin
            out_data  <= skid_data;
            out_sel   <= skid_sel;
            state     <= ONE;
            out_valid <= 1'b1;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_MUX_SELCHK_EN
  // Sticky flag: any accepted select beyond the last input sets it until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
    end else if (accept && !sel_hit) begin
      sel_err <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  // Report each offending accept in simulation
  always_ff @(posedge clk) begin
    if (rst_n && accept && !sel_hit) begin
      $error("pipe_mux_n: out-of-range select %0d accepted (NUM_IN=%0d)", sel, NUM_IN);
    end
  end
`endif
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_mux_n.sv
// tb/tb_pipe_mux_n.sv - directed and scoreboarded bench for pipe_mux_n
module tb_pipe_mux_n;

`ifdef PIPE_MUX_SELCHK_EN
  localparam logic SELCHK = 1'b1;
`else
  localparam logic SELCHK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;

  logic         in_valid, in_ready, out_valid, out_ready, sel_err;
  logic [1:0]   sel, out_sel;
  logic [127:0] in_data;
  logic [31:0]  out_data;

  logic         in_valid3, in_ready3, out_valid3, out_ready3, sel_err3;
  logic [1:0]   sel3, out_sel3;
  logic [95:0]  in_data3;
  logic [31:0]  out_data3;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pipe_mux_n #(.WIDTH(32), .NUM_IN(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .sel(sel), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sel(out_sel), .sel_err(sel_err)
  );

  pipe_mux_n #(.WIDTH(32), .NUM_IN(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid3), .in_ready(in_ready3), .sel(sel3), .in_data(in_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .out_sel(out_sel3), .sel_err(sel_err3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = 2'd0; in_data = '0;
    in_valid3 = 1'b0; out_ready3 = 1'b0; sel3 = 2'd0; in_data3 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
    total++; if (out_data !== 32'h0 || out_sel !== 2'd0) $display("FAIL reset_data got %h/%0d want 0/0", out_data, out_sel); else passed++;
    total++; if (sel_err !== 1'b0) $display("FAIL reset_sel_err got %b want 0", sel_err); else passed++;
  endtask

  task automatic test_single();
    in_data = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    out_ready = 1'b1; sel = 2'd2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) $display("FAIL single_valid got %b want 1", out_valid); else passed++;
    total++; if (out_data !== 32'hCCCC0002 || out_sel !== 2'd2) $display("FAIL single_data got %h/%0d want cccc0002/2", out_data, out_sel); else passed++;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL single_drain got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [4];
    exp[0] = 32'hAAAA0000; exp[1] = 32'hBBBB0001; exp[2] = 32'hCCCC0002; exp[3] = 32'hDDDD0003;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      step();
      total++; if (in_ready !== 1'b1) $display("FAIL b2b_ready%0d got %b want 1", i, in_ready); else passed++;
      total++; if (out_valid !== 1'b1 || out_data !== exp[i] || out_sel !== 2'(i))
        $display("FAIL b2b_data%0d got %b/%h want 1/%h", i, out_valid, out_data, exp[i]); else passed++;
    end
    in_valid = 1'b0;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL b2b_drain got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_stall();
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd1;
    step();
    total++; if (in_ready !== 1'b1 || out_data !== 32'hBBBB0001) $display("FAIL stall_one got %b/%h want 1/bbbb0001", in_ready, out_data); else passed++;
    sel = 2'd3;
    step();
    total++; if (in_ready !== 1'b0) $display("FAIL stall_full_ready got %b want 0", in_ready); else passed++;
    sel = 2'd0;
    step();
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'hBBBB0001)
      $display("FAIL stall_hold got %b/%b/%h want 0/1/bbbb0001", in_ready, out_valid, out_data); else passed++;
    out_ready = 1'b1;
    step();
    total++; if (out_data !== 32'hDDDD0003 || out_sel !== 2'd3 || in_ready !== 1'b1)
      $display("FAIL stall_second got %h/%0d/%b want dddd0003/3/1", out_data, out_sel, in_ready); else passed++;
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_data !== 32'hAAAA0000 || out_sel !== 2'd0)
      $display("FAIL stall_third got %b/%h want 1/aaaa0000", out_valid, out_data); else passed++;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL stall_drain got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_out_of_range();
    in_data3 = {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    out_ready3 = 1'b1; in_valid3 = 1'b1; sel3 = 2'd3;
    step();
    sel3 = 2'd1;
    total++; if (out_valid3 !== 1'b1 || out_data3 !== 32'h0 || out_sel3 !== 2'd3)
      $display("FAIL oor_data got %b/%h/%0d want 1/00000000/3", out_valid3, out_data3, out_sel3); else passed++;
    total++; if (sel_err3 !== SELCHK) $display("FAIL oor_flag got %b want %b", sel_err3, SELCHK); else passed++;
    step();
    in_valid3 = 1'b0;
    total++; if (out_data3 !== 32'hBBBB0001) $display("FAIL oor_valid_after got %h want bbbb0001", out_data3); else passed++;
    total++; if (sel_err3 !== SELCHK) $display("FAIL oor_sticky got %b want %b", sel_err3, SELCHK); else passed++;
    step();
    total++; if (sel_err !== 1'b0) $display("FAIL pow2_flag got %b want 0", sel_err); else passed++;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
    step();
    sel = 2'd1;
    step();
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) $display("FAIL rst_fill got %b want 0", in_ready); else passed++;
    #3 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL rst_async got %b/%b want 0/1", out_valid, in_ready); else passed++;
    total++; if (sel_err3 !== 1'b0 || out_data !== 32'h0) $display("FAIL rst_clear got %b/%h want 0/0", sel_err3, out_data); else passed++;
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (out_valid !== 1'b0) $display("FAIL rst_stale%0d got %b want 0", i, out_valid); else passed++;
    end
  endtask

  task automatic test_random();
    logic [31:0] words [4];
    logic [33:0] q [$];
    logic [33:0] exp;
    logic        prev_stall;
    logic [31:0] prev_data;
    logic [1:0]  prev_sel;
    int          acc;
    acc = 0; prev_stall = 1'b0; prev_data = '0; prev_sel = '0;
    for (int cyc = 0; cyc < 20000 && !(acc >= 1000 && q.size() == 0); cyc++) begin
      if (prev_stall) begin
        total++; if (out_data !== prev_data || out_sel !== prev_sel)
          $display("FAIL rand_stable got %h/%0d want %h/%0d", out_data, out_sel, prev_data, prev_sel); else passed++;
      end
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (acc < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      sel       = 2'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++) words[k] = $urandom;
      in_data = {words[3], words[2], words[1], words[0]};
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin
          $display("FAIL rand_extra got %h want no word", out_data);
        end else begin
          exp = q.pop_front();
          if ({out_sel, out_data} !== exp) $display("FAIL rand_order got %h want %h", {out_sel, out_data}, exp); else passed++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back({sel, words[sel]});
        acc++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_sel   = out_sel;
      step();
    end
    in_valid = 1'b0;
    total++; if (acc < 1000 || q.size() != 0) $display("FAIL rand_timeout got acc=%0d left=%0d want 1000/0", acc, q.size()); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_out_of_range();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_mux_n.md
Name: pipe_mux_n

Overview:
Parametrised N-way datapath multiplexer with a registered, elastic output stage, for pipeline-register boundaries in the CPU such as forwarding-source selection and writeback-source selection. The select is sampled together with the input data under a valid/ready handshake. The selected word is held in a 2-entry skid buffer, so ready is fully registered and a downstream stall causes no loss of throughput. Out-of-range selects produce zero data, consistent with the existing combinational muxes.

Parameters:
WIDTH, 32, data word width in bits
NUM_IN, 4, number of data inputs (2..16)
SEL_W, $clog2(NUM_IN) (minimum 1), select width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous reset, active low
in_valid  input  1  upstream has a word
in_ready  output  1  block can accept a word; driven from a register
sel  input  SEL_W  input select, sampled with in_valid
in_data  input  NUM_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH]
out_valid  output  1  out_data is valid
out_ready  input  1  downstream accepts
out_data  output  WIDTH  selected word
out_sel  output  SEL_W  select value that produced out_data
sel_err  output  1  sticky out-of-range-select flag (see Optional Feature)

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low on rst_n. All state uses clk rising edge.
- Reset values:
  - state=EMPTY
  - out_valid=0, in_ready=1
  - out_data=0, out_sel=0, sel_err=0
  - skid registers=0
- Handshake events:
  - accept = in_valid & in_ready
  - pop = out_valid & out_ready
- Selection: word = in_data slice[sel] when sel < NUM_IN, otherwise all zeros. The select is evaluated on the accept cycle only.
- Latency: 1 cycle. A word accepted in cycle t is on out_data with out_valid=1 in cycle t+1 when the buffer was empty, or when it was ONE and popped in t.
- States (the state register drives the outputs directly):
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: out_valid=1, in_ready=1. Main register full.
  - TWO: out_valid=1, in_ready=0. Main and skid registers full.
- Transitions:
  - EMPTY, accept -> ONE; main <= word.
  - ONE, accept & !pop -> TWO; skid <= word; main is held.
  - ONE, pop & !accept -> EMPTY.
  - ONE, accept & pop -> ONE; main <= word.
  - TWO, pop -> ONE; main <= skid. No accept is possible in TWO.
  - Any other combination: hold state and registers.
- Ordering: strict FIFO, no reordering, no drop, no duplication.
- Stability: while out_valid=1 & out_ready=0, out_data and out_sel are stable.
- Data independence: in_data and sel are ignored when in_valid=0 or in_ready=0.
- Reset mid-operation: contents are discarded immediately; no partial word is emitted after reset release.
- Throughput: one word per cycle in steady state with out_ready held at 1.

Optional Feature:
Macro PIPE_MUX_SELCHK_EN.
- Defined:
  - sel_err sets on any accept with sel >= NUM_IN and stays set until rst_n is asserted.
  - Simulation only: $error message on the offending accept.
- Undefined:
  - sel_err tied to 0.
  - Out-of-range accepts still yield zero data, with no flag.
- With NUM_IN a power of two, the flag never sets.

Test Plan:
1. Reset, then NUM_IN=4, in_data={0xDDDD0003,0xCCCC0002,0xBBBB0001,0xAAAA0000}, sel=2, in_valid=1 for 1 cycle, out_ready=1 -> next cycle out_valid=1, out_data=0xCCCC0002, out_sel=2; following cycle out_valid=0.
2. Stream sel=0,1,2,3 on back-to-back cycles, out_ready=1 -> out_data 0xAAAA0000, 0xBBBB0001, 0xCCCC0002, 0xDDDD0003 on consecutive cycles; in_ready stays 1 throughout.
3. out_ready=0, stream 3 words with sel=1, 3, 0 -> in_ready drops after 2 accepts; out_data holds 0xBBBB0001. Raise out_ready -> outputs 0xBBBB0001 then 0xDDDD0003, then the third word 0xAAAA0000 is accepted and output; nothing is lost.
4. NUM_IN=3 build, sel=3 accepted -> out_data=0. With PIPE_MUX_SELCHK_EN, sel_err=1 from the next cycle and stays 1 through later valid selects. Without the macro, sel_err=0.
5. Fill to TWO with out_ready=0, then pulse rst_n low asynchronously mid-cycle -> out_valid=0, in_ready=1, sel_err=0 immediately. After release, no stale word appears.
6. Random in_valid/out_ready (50%) with 1000 random sel/data -> scoreboard shows exact FIFO match. out_data is never changed while out_valid & !out_ready.
